// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter / next-address sequencer driving the return-address stack
//   Sys_Clock, Reset (sync, active-high); Stall, Halt, Resume, Jump, Branch, Cond, Call, Ret,
//   Target, Ret_Add, Stack_Err in; PC (registered), NPPC (PC+1), Stack_Enable, Stack_Write,
//   Halted, Seq_Err out.
module pc_sequencer #(
  parameter logic [7:0] RESET_VECTOR = 8'h00
) (
  input  logic       Sys_Clock,
  input  logic       Reset,
  input  logic       Stall,
  input  logic       Halt,
  input  logic       Resume,
  input  logic       Jump,
  input  logic       Branch,
  input  logic       Cond,
  input  logic       Call,
  input  logic       Ret,
  input  logic [7:0] Target,
  input  logic [7:0] Ret_Add,
  input  logic       Stack_Err,
  output logic [7:0] PC,
  output logic [7:0] NPPC,
  output logic       Stack_Enable,
  output logic       Stack_Write,
  output logic       Halted,
  output logic       Seq_Err
);
  typedef enum logic [1:0] {RUN, RET_WAIT, HALT, ERROR} state_t;
  state_t state, state_nx;
  logic [7:0] pc_nx;
  logic active;
  always_ff @(posedge Sys_Clock) begin
    if (Reset) begin
      state <= RUN;
      PC    <= RESET_VECTOR;
    end else begin
      state <= state_nx;
      PC    <= pc_nx;
    end
  end
  // Stack requests are only issued from an unstalled RUN cycle not preempted by Halt;
  // Ret outranks Call, so a push only happens when Ret is low.
  assign active       = !Reset && state == RUN && !Stall && !Halt;
  assign Stack_Enable = active && (Ret || Call);
  assign Stack_Write  = active && !Ret && Call;
  assign NPPC         = PC + 8'd1;
  assign Halted       = state == HALT;
  assign Seq_Err      = state == ERROR;
  always_comb begin
    state_nx = state;
    pc_nx    = PC;
    case (state)
      RUN: if (!Stall) begin
        if (Halt) state_nx = HALT;
        else if (Ret) state_nx = Stack_Err ? ERROR : RET_WAIT;
        else if (Call) begin
          state_nx = Stack_Err ? ERROR : RUN;
          pc_nx    = Stack_Err ? PC : Target;
        end else pc_nx = (Jump || (Branch && Cond)) ? Target : NPPC;
      end
      RET_WAIT: begin
        state_nx = RUN;
        pc_nx    = Ret_Add;
      end
      HALT: if (Resume) begin
        state_nx = RUN;
        pc_nx    = NPPC;
      end
      default: ;
    endcase
  end
endmodule
